// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end
package fetch_pkg;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_DRAIN} fetch_state_e;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous instruction buffer with push/pop/flush and occupancy count
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           din,
    output fetch_entry_t           dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    assign dout = mem[rd_ptr];
    // pointer and occupancy bookkeeping; flush empties the buffer in one cycle
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // storage array, written only on push
    always_ff @(posedge clk) if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, imem request/credit logic, redirect draining; perf counters under FETCH_PERF_CNT_EN
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          MAX_OUT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] addr_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_bubble_cnt_o
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    fetch_state_e state, state_nxt;
    logic [31:0]  pc;
    logic [CW-1:0] outstanding, outstanding_nxt, discard, discard_nxt, occupancy, inflight;
    logic [CW:0]  credit_use;
    logic         redir_q, req_held, fire, rv, push, pop;
    fetch_entry_t head, din;

    assign inst_valid_o = occupancy != '0;
    assign addr_o       = inst_valid_o ? head.addr : '0;
    assign inst_o       = inst_valid_o ? head.inst : NOP_INST;
    assign inflight     = outstanding + discard;
    assign rv           = imem_rvalid_i && inflight != '0;
    assign pop          = inst_valid_o && !stall_i && !redirect_i;
    assign push         = rv && discard == '0 && !redirect_i;
    // the head leaving this cycle frees its slot, so a full-rate stream needs only two entries
    assign credit_use   = {1'b0, occupancy} + {1'b0, outstanding} - (CW+1)'(pop);
    assign imem_req_o   = !rst && state == S_RUN && !redir_q &&
                          (req_held || (credit_use < (CW+1)'(FIFO_DEPTH) && outstanding < CW'(MAX_OUT)));
    assign imem_addr_o  = rst ? RESET_PC : pc;
    assign fire         = imem_req_o && imem_gnt_i;
    // responses are in order, so the oldest live request sits outstanding words behind pc
    assign din          = '{addr: pc - 32'({outstanding, 2'b00}), inst: imem_rdata_i};

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .flush(redirect_i),
        .din  (din),
        .dout (head),
        .count(occupancy)
    );

    // next-state: a redirect turns everything in flight into words to discard
    always_comb begin
        outstanding_nxt = redirect_i ? '0 : outstanding + CW'(fire) - CW'(push);
        discard_nxt     = redirect_i ? inflight + CW'(fire) - CW'(rv) : discard - CW'(rv && discard != '0);
        state_nxt       = state == S_BOOT ? S_RUN
                        : state == S_RUN  ? ((redirect_i && (outstanding != '0 || fire)) ? S_DRAIN : S_RUN)
                        : (discard_nxt == '0 ? S_RUN : S_DRAIN);
    end

    // state, PC and in-flight accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_BOOT;
            pc          <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            redir_q     <= 1'b0;
            req_held    <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= redirect_i ? (redirect_pc_i & ~32'h3) : pc + (fire ? 32'd4 : 32'd0);
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;
            redir_q     <= redirect_i;
            req_held    <= imem_req_o && !imem_gnt_i && !redirect_i;
        end
    end

    // a response with nothing in flight is a memory protocol error and is ignored
    always_ff @(posedge clk) begin
        if (!rst && imem_rvalid_i) assert (inflight != '0) else $error("fetch_unit: rvalid with no request in flight");
    end

`ifdef FETCH_PERF_CNT_EN
    // saturating stall and bubble counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt_o  <= '0;
            perf_bubble_cnt_o <= '0;
        end else begin
            if (inst_valid_o && stall_i && ~&perf_stall_cnt_o) perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            if (!inst_valid_o && ~&perf_bubble_cnt_o) perf_bubble_cnt_o <= perf_bubble_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an address scoreboard and memory model
module tb_fetch_unit;
    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0, gnt = 1'b1, rvalid = 1'b0, hold = 1'b0;
    logic [31:0] redirect_pc = '0, rdata = '0;
    logic        req, valid;
    logic [31:0] imem_addr, addr, inst;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall, perf_bubble;
`endif
    int          tests = 0, fails = 0;
    logic [31:0] sb[$];
    logic [31:0] pend[$];
    logic [31:0] exp_pc = '0;

    fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .imem_req_o       (req),
        .imem_addr_o      (imem_addr),
        .imem_gnt_i       (gnt),
        .imem_rvalid_i    (rvalid),
        .imem_rdata_i     (rdata),
        .addr_o           (addr),
        .inst_o           (inst),
        .inst_valid_o     (valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt_o (perf_stall),
        .perf_bubble_cnt_o(perf_bubble)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one clock: scoreboard at mid-cycle, then memory response for the next cycle
    task automatic tick();
        @(negedge clk);
        if (rst) begin
            sb.delete();
            pend.delete();
            exp_pc = '0;
        end else begin
            if (!valid) chk("bubble_nop", inst, 32'h13);
            if (valid && !stall && !redirect) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    chk("sb_addr", addr, sb[0]);
                    chk("sb_inst", inst, sb[0] | 32'h1);
                    void'(sb.pop_front());
                end
            end
            if (req && gnt) begin
                chk("req_addr", imem_addr, exp_pc);
                sb.push_back(exp_pc);
                pend.push_back(exp_pc);
                exp_pc += 4;
            end
            if (redirect) begin
                sb.delete();
                exp_pc = {redirect_pc[31:2], 2'b00};
            end
        end
        @(posedge clk);
        #1;
        redirect = 1'b0;
        rvalid   = !rst && !hold && pend.size() != 0;
        rdata    = '0;
        if (rvalid) rdata = pend.pop_front() | 32'h1;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_req", req, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_addr", addr, 0);
        chk("rst_inst", inst, 32'h13);
        chk("rst_valid", valid, 0);
        rst = 1'b0;
        tick();
        chk("t1_req_c1", req, 1);
        chk("t1_req_addr_c1", imem_addr, 0);
        tick();
        chk("t1_valid_c2", valid, 0);
        tick();
        chk("t1_valid_c3", valid, 1);
        chk("t1_addr_c3", addr, 0);
        chk("t1_inst_c3", inst, 32'h1);
        tick();
        chk("t1_addr_c4", addr, 32'h4);
        chk("t1_inst_c4", inst, 32'h5);
        tick();
        chk("t1_addr_c5", addr, 32'h8);
        chk("t1_inst_c5", inst, 32'h9);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_hold_valid", valid, 1);
            chk("t2_hold_addr", addr, 32'h8);
            chk("t2_hold_inst", inst, 32'h9);
            chk("t2_no_credit_req", req, 0);
        end
        stall = 1'b0;
        repeat (4) tick();
        hold = 1'b1;
        repeat (3) tick();
        chk("t3_full_out_req", req, 0);
        redirect_pc = 32'h100;
        redirect = 1'b1;
        tick();
        hold = 1'b0;
        chk("t3_flush_valid", valid, 0);
        chk("t3_drain_req", req, 0);
        for (int i = 0; i < 10 && !req; i++) tick();
        chk("t3_resume_req", req, 1);
        chk("t3_resume_addr", imem_addr, 32'h100);
        for (int i = 0; i < 10 && !valid; i++) tick();
        chk("t3_first_valid", valid, 1);
        chk("t3_first_addr", addr, 32'h100);
        chk("t3_first_inst", inst, 32'h101);
        repeat (5) tick();
        chk("t4_pre_rvalid", valid, 1);
        stall = 1'b1;
        redirect_pc = 32'h203;
        redirect = 1'b1;
        tick();
        stall = 1'b0;
        chk("t4_flush_valid", valid, 0);
        chk("t4_flush_inst", inst, 32'h13);
        for (int i = 0; i < 10 && !valid; i++) tick();
        chk("t4_first_valid", valid, 1);
        chk("t4_first_addr", addr, 32'h200);
        chk("t4_first_inst", inst, 32'h201);
        repeat (4) tick();
        gnt = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_req_held", req, 1);
            chk("t5_addr_held", imem_addr, exp_pc);
            chk("t5_valid", valid, 0);
            chk("t5_inst", inst, 32'h13);
        end
        gnt = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("t5_rst_req", req, 0);
        chk("t5_rst_imem_addr", imem_addr, 0);
        chk("t5_rst_addr", addr, 0);
        chk("t5_rst_inst", inst, 32'h13);
        chk("t5_rst_valid", valid, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("t6_rst_stall_cnt", perf_stall, 0);
        chk("t6_rst_bubble_cnt", perf_bubble, 0);
`endif
        rst = 1'b0;
        repeat (3) tick();
        chk("t5_restart_valid", valid, 1);
        chk("t5_restart_addr", addr, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("t6_bubble_cnt_boot", perf_bubble, 3);
        chk("t6_stall_cnt_boot", perf_stall, 0);
`endif
        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        chk("t6_stall_cnt", perf_stall, 3);
        chk("t6_bubble_cnt", perf_bubble, 3);
`endif
        repeat (4) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
